// File: rtl/wimpfi_pkg.sv
// Shared wimpFi transmit types and the Manchester line-encoding helper.
package wimpfi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    EOF  = 2'd2
  } tx_state_t;

  // IEEE convention: a 0 is sent high-then-low, a 1 is sent low-then-high.
  function automatic logic manchester_enc(input logic b, input logic half);
    return b ~^ half;
  endfunction

endpackage

// File: rtl/manchester_tx_if.sv
// MAC-to-transmitter byte handshake plus the line outputs toward the failsafe.
interface manchester_tx_if;
  // A byte moves on every rising clk edge where valid && rdy. rdy never looks
  // at valid, and valid may drop at any time; data only matters while valid=1.
  logic [7:0] data;
  logic       valid;
  logic       rdy;
  logic       txd;
  logic       txen;

  modport master (
    output data,
    output valid,
    input  rdy,
    input  txd,
    input  txen
  );

  modport slave (
    input  data,
    input  valid,
    output rdy,
    output txd,
    output txen
  );
endinterface

// File: rtl/manchester_tx_half_bit_timer.sv
// Free-running half-bit period timer; tick marks the last cycle of each half-bit.
module half_bit_timer #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int RATE_HZ = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  // HB must come out as an integer of at least 2 for the line timing to hold.
  localparam int HB = CLK_HZ / (2 * RATE_HZ);
  localparam int CW = (HB > 1) ? $clog2(HB) : 1;
  localparam logic [CW-1:0] LAST = CW'(HB - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/manchester_tx.sv
// Byte-stream Manchester transmitter: LSB-first serialiser with a one-byte
// look-ahead register so back-to-back bytes share a frame, then an idle-high EOF.
module manchester_tx
  import wimpfi_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int BIT_RATE = 50000,
  parameter int EOF_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  manchester_tx_if.slave    bus,
  output tx_state_t         dbg_state_o
);
  localparam int EOF_TICKS = 2 * EOF_BITS;
  localparam int EW        = $clog2(2 * EOF_BITS + 1);
  localparam logic [EW-1:0] EOF_LAST = EW'(EOF_TICKS - 1);

  tx_state_t     state_q, state_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    nxt_q, nxt_d;
  logic          pend_q, pend_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic          half_q, half_d;
  logic [EW-1:0] eofcnt_q, eofcnt_d;

  logic tick;
  logic clr;
  logic rdy_w;
  logic accept;

  half_bit_timer #(
    .CLK_HZ (CLK_HZ),
    .RATE_HZ(BIT_RATE)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .tick(tick)
  );

  // The look-ahead window is the second half of bit 7, closed once it holds a byte.
  assign rdy_w  = (state_q == IDLE) ||
                  ((state_q == SEND) && (bitcnt_q == 3'd7) && half_q && !pend_q);
  assign accept = bus.valid && rdy_w;

  assign bus.rdy     = rdy_w;
  assign bus.txen    = (state_q != IDLE);
  assign bus.txd     = (state_q == SEND) ? manchester_enc(shreg_q[0], half_q) : 1'b1;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    nxt_d    = nxt_q;
    pend_d   = pend_q;
    bitcnt_d = bitcnt_q;
    half_d   = half_q;
    eofcnt_d = eofcnt_q;
    clr      = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d  = bus.data;
          bitcnt_d = 3'd0;
          half_d   = 1'b0;
          pend_d   = 1'b0;
          clr      = 1'b1;
          state_d  = SEND;
        end
      end

      SEND: begin
        if (accept) begin
          nxt_d  = bus.data;
          pend_d = 1'b1;
        end
        if (tick) begin
          if (!half_q) begin
            half_d = 1'b1;
          end else begin
            half_d = 1'b0;
            if (bitcnt_q == 3'd7) begin
              // A byte arriving on the final tick itself goes straight to the shifter.
              if (pend_q || accept) begin
                shreg_d  = pend_q ? nxt_q : bus.data;
                bitcnt_d = 3'd0;
                pend_d   = 1'b0;
              end else begin
                state_d  = EOF;
                eofcnt_d = '0;
              end
            end else begin
              shreg_d  = {1'b0, shreg_q[7:1]};
              bitcnt_d = bitcnt_q + 3'd1;
            end
          end
        end
      end

      EOF: begin
        if (tick) begin
          if (eofcnt_q == EOF_LAST) begin
            eofcnt_d = '0;
            state_d  = IDLE;
          end else begin
            eofcnt_d = eofcnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      nxt_q    <= '0;
      pend_q   <= 1'b0;
      bitcnt_q <= '0;
      half_q   <= 1'b0;
      eofcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      nxt_q    <= nxt_d;
      pend_q   <= pend_d;
      bitcnt_q <= bitcnt_d;
      half_q   <= half_d;
      eofcnt_q <= eofcnt_d;
    end
  end
endmodule

// File: tb/tb_manchester_tx.sv
// Directed bench for manchester_tx at HB=10 cycles, EOF_BITS=2.
module tb_manchester_tx;
  import wimpfi_pkg::*;

  localparam int CLK_HZ   = 1_000_000;
  localparam int BIT_RATE = 50000;
  localparam int EOF_BITS = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  manchester_tx_if bus();
  tx_state_t dbg_state;

  manchester_tx #(
    .CLK_HZ  (CLK_HZ),
    .BIT_RATE(BIT_RATE),
    .EOF_BITS(EOF_BITS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;
  int acc_cnt = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0]  data;
    logic [0:15] halves;
    int          gap;
  } vec_t;

  vec_t vecs[4];

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst && bus.valid && bus.rdy) begin
      logic [7:0] exp_b;
      acc_cnt++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL accept_unexpected @%0t: got %0h expected none", $time, bus.data);
      end else begin
        exp_b = exp_q.pop_front();
        if (bus.data !== exp_b) begin
          n_err++;
          $display("FAIL accept_data @%0t: got %0h expected %0h", $time, bus.data, exp_b);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Presents a byte while IDLE; returns sampling cycle 1 of the new frame.
  task automatic send_idle(input logic [7:0] d);
    check("idle_rdy", {31'd0, bus.rdy}, 32'd1);
    bus.valid = 1'b1;
    bus.data  = d;
    exp_q.push_back(d);
    step();
    bus.valid = 1'b0;
    bus.data  = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_frame_end(input int start_len, output int len);
    len = start_len;
    for (int i = 0; i < 600; i++) begin
      step();
      if (bus.txen !== 1'b1) break;
      len++;
    end
  endtask

  function automatic logic exp_txd1(input int k, input logic [0:15] h);
    if (k >= 1 && k <= 160) return h[(k - 1) / 10];
    return 1'b1;
  endfunction

  function automatic logic exp_txd2(input int k, input logic [0:15] h0, input logic [0:15] h1);
    if (k >= 1 && k <= 160) return h0[(k - 1) / 10];
    if (k > 160 && k <= 320) return h1[(k - 161) / 10];
    return 1'b1;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    int base;
    int len;
    logic [0:15] h00;
    logic [0:15] hff;

    vecs[0] = '{data: 8'hA5, halves: 16'b0110011010011001, gap: 0};
    vecs[1] = '{data: 8'h00, halves: 16'b1010101010101010, gap: 3};
    vecs[2] = '{data: 8'hFF, halves: 16'b0101010101010101, gap: 1};
    vecs[3] = '{data: 8'h3C, halves: 16'b1010010101011010, gap: 6};
    h00 = 16'b1010101010101010;
    hff = 16'b0101010101010101;

    bus.valid = 1'b0;
    bus.data  = 8'h00;

    // Reset values.
    step_n(3);
    check("rst_txen", {31'd0, bus.txen}, 32'd0);
    check("rst_txd", {31'd0, bus.txd}, 32'd1);
    check("rst_rdy", {31'd0, bus.rdy}, 32'd1);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b1;
    step_n(2);
    check("post_rst_txen", {31'd0, bus.txen}, 32'd0);

    // Single-byte frames, checked every cycle through the first IDLE cycle.
    for (int v = 0; v < 4; v++) begin
      step_n(vecs[v].gap);
      send_idle(vecs[v].data);
      for (int k = 1; k <= 201; k++) begin
        check("frame_txen", {31'd0, bus.txen}, {31'd0, (k <= 200)});
        check("frame_txd", {31'd0, bus.txd}, {31'd0, exp_txd1(k, vecs[v].halves)});
        check("frame_rdy", {31'd0, bus.rdy}, {31'd0, ((k >= 151 && k <= 160) || k > 200)});
        if (k < 201) step();
      end
    end

    // Back-to-back 00, FF with valid held high.
    base = acc_cnt;
    step_n(2);
    bus.valid = 1'b1;
    bus.data  = 8'h00;
    exp_q.push_back(8'h00);
    step();
    for (int k = 1; k <= 361; k++) begin
      check("b2b_txen", {31'd0, bus.txen}, {31'd0, (k <= 360)});
      check("b2b_txd", {31'd0, bus.txd}, {31'd0, exp_txd2(k, h00, hff)});
      check("b2b_rdy", {31'd0, bus.rdy},
            {31'd0, (k == 151 || (k >= 311 && k <= 320) || k == 361)});
      if (k == 1) begin
        bus.data = 8'hFF;
        exp_q.push_back(8'hFF);
      end
      if (acc_cnt - base >= 2) bus.valid = 1'b0;
      if (k < 361) step();
    end
    check("b2b_accepts", 32'(acc_cnt - base), 32'd2);

    // rdy window opens at cycle 151; then late valid during EOF.
    base = acc_cnt;
    send_idle(8'h5A);
    step_n(149);
    check("win_rdy_150", {31'd0, bus.rdy}, 32'd0);
    bus.valid = 1'b1;
    bus.data  = 8'hC3;
    exp_q.push_back(8'hC3);
    step();
    check("win_noacc_151", 32'(acc_cnt - base), 32'd1);
    check("win_rdy_151", {31'd0, bus.rdy}, 32'd1);
    step();
    check("win_acc_152", 32'(acc_cnt - base), 32'd2);
    check("win_rdy_152", {31'd0, bus.rdy}, 32'd0);
    bus.valid = 1'b0;
    for (int k = 153; k <= 160; k++) begin
      step();
      check("win_rdy_closed", {31'd0, bus.rdy}, 32'd0);
    end
    step();
    check("b2_state_161", 32'(dbg_state), 32'(SEND));
    check("b2_txd_161", {31'd0, bus.txd}, 32'd0);
    step_n(160);
    check("eof_state_321", 32'(dbg_state), 32'(EOF));
    check("eof_txd_321", {31'd0, bus.txd}, 32'd1);
    check("eof_txen_321", {31'd0, bus.txen}, 32'd1);
    step_n(4);
    bus.valid = 1'b1;
    bus.data  = 8'h81;
    exp_q.push_back(8'h81);
    for (int k = 326; k <= 360; k++) begin
      step();
      check("eof_rdy", {31'd0, bus.rdy}, 32'd0);
    end
    check("eof_noacc", 32'(acc_cnt - base), 32'd2);
    step();
    check("late_idle_txen", {31'd0, bus.txen}, 32'd0);
    check("late_idle_rdy", {31'd0, bus.rdy}, 32'd1);
    step();
    bus.valid = 1'b0;
    check("late_acc", 32'(acc_cnt - base), 32'd3);
    check("late_txen", {31'd0, bus.txen}, 32'd1);
    check("late_txd", {31'd0, bus.txd}, 32'd0);
    wait_frame_end(1, len);
    check("late_frame_len", 32'(len), 32'd200);

    // Byte offered on the final tick of the previous byte.
    base = acc_cnt;
    step_n(3);
    send_idle(8'h0F);
    step_n(159);
    check("ft_rdy_160", {31'd0, bus.rdy}, 32'd1);
    check("ft_txd_160", {31'd0, bus.txd}, 32'd0);
    bus.valid = 1'b1;
    bus.data  = 8'hF0;
    exp_q.push_back(8'hF0);
    step();
    bus.valid = 1'b0;
    check("ft_acc", 32'(acc_cnt - base), 32'd2);
    check("ft_state_161", 32'(dbg_state), 32'(SEND));
    check("ft_txd_161", {31'd0, bus.txd}, 32'd1);
    step_n(10);
    check("ft_txd_171", {31'd0, bus.txd}, 32'd0);
    wait_frame_end(171, len);
    check("ft_frame_len", 32'(len), 32'd360);

    // Asynchronous reset mid-byte.
    send_idle(8'hA5);
    step_n(74);
    #2;
    rst = 1'b0;
    #1;
    check("arst_txen", {31'd0, bus.txen}, 32'd0);
    check("arst_txd", {31'd0, bus.txd}, 32'd1);
    check("arst_rdy", {31'd0, bus.rdy}, 32'd1);
    check("arst_state", 32'(dbg_state), 32'(IDLE));
    step_n(2);
    rst = 1'b1;
    for (int k = 0; k < 25; k++) begin
      step();
      check("arst_stay_idle", 32'(dbg_state), 32'(IDLE));
      check("arst_stay_txen", {31'd0, bus.txen}, 32'd0);
    end

    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
